// File: rtl/uart_rx_word_if.sv
// uart_rx_word_if: serial input, FIFO write port and status pulses of the word receiver
interface uart_rx_word_if;
  logic        rx;
  logic        wrfull;
  logic [15:0] dataout;
  logic        wrreq;
  logic        frame_err;
  logic        overflow;
  logic        pair_timeout;
  logic        busy;
  modport master (input rx, wrfull, output dataout, wrreq, frame_err, overflow, pair_timeout, busy);
  modport slave (output rx, wrfull, input dataout, wrreq, frame_err, overflow, pair_timeout, busy);
endinterface

// File: rtl/uart_rx_word.sv
// uart_rx_word: oversampled 8N1 receiver pairing bytes low-first into 16-bit FIFO writes
module uart_rx_word #(
  parameter int OVERSAMPLE   = 16,
  parameter int PAIR_TIMEOUT = 320
) (
  input logic             clkout,
  input logic             reset_ayn,
  uart_rx_word_if.master  bus
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int TW = $clog2(PAIR_TIMEOUT + 1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(PAIR_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic          rx_m_q, rx_s_q, rx_d_q;
  logic [SW-1:0] samp_q, samp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d, low_q, low_d;
  logic          half_q, half_d;
  logic [TW-1:0] to_q, to_d;
  logic [15:0]   dataout_q, dataout_d;
  logic          wrreq_q, wrreq_d, frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d, pair_timeout_q, pair_timeout_d;
  logic          fall, stop_hit, idle_half;
  always_comb begin
    fall           = rx_d_q & ~rx_s_q;
    stop_hit       = (state_q == STOP) && (samp_q == S_LAST);
    idle_half      = (state_q == IDLE) && half_q;
    state_d        = state_q;
    samp_d         = samp_q + 1'b1;
    bit_d          = bit_q;
    byte_d         = byte_q;
    low_d          = low_q;
    half_d         = half_q;
    dataout_d      = dataout_q;
    wrreq_d        = 1'b0;
    frame_err_d    = 1'b0;
    overflow_d     = 1'b0;
    pair_timeout_d = 1'b0;
    to_d           = idle_half ? to_q + 1'b1 : '0;
    case (state_q)
      IDLE: begin
        samp_d  = '0;
        state_d = fall ? START : IDLE;
      end
      START: if (samp_q == S_HALF) begin
        samp_d  = '0;
        bit_d   = '0;
        state_d = rx_s_q ? IDLE : DATA;
      end
      DATA: if (samp_q == S_LAST) begin
        samp_d  = '0;
        byte_d  = {rx_s_q, byte_q[7:1]};
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'd7) ? STOP : DATA;
      end
      default: if (samp_q == S_LAST) begin
        samp_d  = '0;
        state_d = IDLE;
      end
    endcase
    if (stop_hit) begin
      if (!rx_s_q) begin
        frame_err_d = 1'b1;
        half_d      = 1'b0;
      end else if (!half_q) begin
        low_d  = byte_q;
        half_d = 1'b1;
      end else begin
        half_d     = 1'b0;
        overflow_d = bus.wrfull;
        wrreq_d    = ~bus.wrfull;
        dataout_d  = bus.wrfull ? dataout_q : {byte_q, low_q};
      end
    end
    // a start edge in the expiry cycle takes priority over discarding the low byte
    if (idle_half && (to_q == T_LAST) && !fall) begin
      half_d         = 1'b0;
      pair_timeout_d = 1'b1;
      to_d           = '0;
    end
  end
  always_ff @(posedge clkout or negedge reset_ayn) begin
    if (!reset_ayn) begin
      state_q        <= IDLE;
      rx_m_q         <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_d_q         <= 1'b1;
      samp_q         <= '0;
      bit_q          <= '0;
      byte_q         <= '0;
      low_q          <= '0;
      half_q         <= 1'b0;
      to_q           <= '0;
      dataout_q      <= '0;
      wrreq_q        <= 1'b0;
      frame_err_q    <= 1'b0;
      overflow_q     <= 1'b0;
      pair_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_m_q         <= bus.rx;
      rx_s_q         <= rx_m_q;
      rx_d_q         <= rx_s_q;
      samp_q         <= samp_d;
      bit_q          <= bit_d;
      byte_q         <= byte_d;
      low_q          <= low_d;
      half_q         <= half_d;
      to_q           <= to_d;
      dataout_q      <= dataout_d;
      wrreq_q        <= wrreq_d;
      frame_err_q    <= frame_err_d;
      overflow_q     <= overflow_d;
      pair_timeout_q <= pair_timeout_d;
    end
  end
  assign bus.dataout      = dataout_q;
  assign bus.wrreq        = wrreq_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.overflow     = overflow_q;
  assign bus.pair_timeout = pair_timeout_q;
  assign bus.busy         = (state_q != IDLE);
endmodule
